// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Aligns and extends load data; holds the read word across stalls.
module mem_stage #(
   parameter int EX_TO_MEM_WD = 150,
   parameter int MEM_TO_WB_WD = 136,
   parameter int MEM_TO_RF_WD = 38,
   parameter int STALL_WD     = 6
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
   output logic [65:0]             mem_hilo_bus
);

   logic [EX_TO_MEM_WD-1:0] r_q, r_d;
   logic                    fresh_q, fresh_d;
   logic [31:0]             rbuf_q, rbuf_d;

   logic [65:0] hilo;
   logic [7:0]  mem_op;
   logic [31:0] pc;
   logic        ram_en;
   logic [3:0]  ram_wen;
   logic        sel_rf_res;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] ex_result;

   assign {hilo, mem_op, pc, ram_en, ram_wen,
           sel_rf_res, rf_we, rf_waddr, ex_result} = r_q;

   logic unused_ok;
   assign unused_ok = &{1'b0, ram_en, ram_wen,
                        stall[5], stall[2:0]};

   // Next state: load, bubble or hold; rbuf keeps the first-cycle word
   always_comb begin
      r_d     = r_q;
      fresh_d = 1'b0;
      rbuf_d  = rbuf_q;
      if (fresh_q) rbuf_d = data_sram_rdata;
      if (!stall[3]) begin
         r_d     = ex_to_mem_bus;
         fresh_d = 1'b1;
      end else if (!stall[4]) begin
         r_d = '0;
      end
   end

   // Stage registers with asynchronous clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_q     <= '0;
         fresh_q <= 1'b0;
         rbuf_q  <= '0;
      end else begin
         r_q     <= r_d;
         fresh_q <= fresh_d;
         rbuf_q  <= rbuf_d;
      end
   end

   logic [31:0] rdata;
   logic [1:0]  a;
   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;

   assign rdata   = fresh_q ? data_sram_rdata : rbuf_q;
   assign a       = ex_result[1:0];
   assign shifted = rdata >> {a, 3'b000};
   assign byte_v  = shifted[7:0];

   // Misaligned halfword falls back to the low half
   always_comb begin
      half_v = rdata[15:0];
      if (!a[0] && a[1]) half_v = rdata[31:16];
   end

   // Load extension, first set load bit wins
   always_comb begin
      load_data = '0;
      if (mem_op[7])
         load_data = {{24{byte_v[7]}}, byte_v};
      else if (mem_op[6])
         load_data = {24'b0, byte_v};
      else if (mem_op[5])
         load_data = {{16{half_v[15]}}, half_v};
      else if (mem_op[4])
         load_data = {16'b0, half_v};
      else if (mem_op[3])
         load_data = rdata;
   end

   // Write-back data select
   always_comb begin
      rf_wdata = ex_result;
      if (sel_rf_res) rf_wdata = load_data;
   end

   assign mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};
   assign mem_to_wb_bus = {hilo, pc, rf_we, rf_waddr, rf_wdata};
   assign mem_hilo_bus  = hilo;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage.
// A behavioural model tracks each instruction's first-cycle read word.
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         resetn;
   logic [5:0]   stall;
   logic [149:0] ex_to_mem_bus;
   logic [31:0]  data_sram_rdata;
   logic [135:0] mem_to_wb_bus;
   logic [37:0]  mem_to_rf_bus;
   logic [65:0]  mem_hilo_bus;

   int tests = 0;
   int fails = 0;

   // model: instruction in MEM, whether this is its first cycle,
   // and the word seen during that first cycle
   logic [149:0] m_instr;
   logic         m_first;
   logic [31:0]  m_held;

   localparam logic [5:0] GO   = 6'b000000;
   localparam logic [5:0] BUB  = 6'b001000;
   localparam logic [5:0] HOLD = 6'b011000;

   mem_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .stall           (stall),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .data_sram_rdata (data_sram_rdata),
      .mem_to_wb_bus   (mem_to_wb_bus),
      .mem_to_rf_bus   (mem_to_rf_bus),
      .mem_hilo_bus    (mem_hilo_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [149:0] mk(
      input logic [65:0] hilo, input logic [7:0] op,
      input logic [31:0] pc, input logic sel, input logic we,
      input logic [4:0] wa, input logic [31:0] res);
      logic       en;
      logic [3:0] wen;
      en  = |op;
      wen = (op[2:0] != 3'b0) ? 4'hF : 4'h0;
      return {hilo, op, pc, en, wen, sel, we, wa, res};
   endfunction

   // architectural meaning of a load, in plain arithmetic
   function automatic logic [31:0] load_value(
      input logic [7:0] op, input int a, input logic [31:0] w);
      logic [31:0] v;
      if (op[7] || op[6]) begin
         v = (w >> (8 * a)) & 32'hFF;
         if (op[7] && v >= 32'd128) v = v + 32'hFFFF_FF00;
         return v;
      end
      if (op[5] || op[4]) begin
         v = (a == 2) ? (w >> 16) : (w & 32'hFFFF);
         if (op[5] && v >= 32'd32768) v = v + 32'hFFFF_0000;
         return v;
      end
      if (op[3]) return w;
      return 32'h0;
   endfunction

   function automatic logic [135:0] exp_wb();
      logic [31:0] w, res, wd;
      logic [7:0]  op;
      w   = m_first ? data_sram_rdata : m_held;
      op  = m_instr[83:76];
      res = m_instr[31:0];
      wd  = m_instr[38] ? load_value(op, int'(res[1:0]), w) : res;
      return {m_instr[149:84], m_instr[75:44],
              m_instr[37], m_instr[36:32], wd};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!resetn) begin
         m_instr = '0; m_first = 1'b0; m_held = '0;
      end else begin
         if (m_first) m_held = data_sram_rdata;
         if (!stall[3]) begin
            m_instr = ex_to_mem_bus; m_first = 1'b1;
         end else if (!stall[4]) begin
            m_instr = '0; m_first = 1'b0;
         end else begin
            m_first = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      stall = 6'h3F;
      ex_to_mem_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
      data_sram_rdata = $urandom;
      tick(); tick();
      @(negedge clk);
      tests++;
      if (mem_to_wb_bus !== '0) begin
         fails++; $display("FAIL reset_wb got %h want 0", mem_to_wb_bus);
      end
      tests++;
      if (mem_to_rf_bus !== '0) begin
         fails++; $display("FAIL reset_rf got %h want 0", mem_to_rf_bus);
      end
      tests++;
      if (mem_hilo_bus !== '0) begin
         fails++; $display("FAIL reset_hilo got %h want 0", mem_hilo_bus);
      end
      resetn = 1'b1;
      stall = GO;
      ex_to_mem_bus = mk('0, 8'h00, 32'h0040_0000, 1'b0, 1'b1, 5'd5,
                         32'h1234);
      tick();
      @(negedge clk);
      tests++;
      if (mem_to_rf_bus !== {1'b1, 5'd5, 32'h0000_1234}) begin
         fails++;
         $display("FAIL first_addu got %h want %h", mem_to_rf_bus,
                  {1'b1, 5'd5, 32'h0000_1234});
      end
   endtask

   task automatic test_load_ext();
      logic [7:0]  ops [5] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08};
      int          offs[5] = '{3, 1, 2, 0, 0};
      logic [31:0] want[5] = '{32'hFFFF_FF80, 32'h0000_007F,
                               32'hFFFF_80FF, 32'h0000_7F01,
                               32'h80FF_7F01};
      for (int i = 0; i < 5; i++) begin
         stall = GO;
         ex_to_mem_bus = mk('0, ops[i], 32'h100 + 32'(i), 1'b1, 1'b1,
                            5'd3, 32'h1000_0000 + 32'(offs[i]));
         tick();
         data_sram_rdata = 32'h80FF_7F01;
         @(negedge clk);
         tests++;
         if (mem_to_rf_bus[31:0] !== want[i]) begin
            fails++;
            $display("FAIL load_ext[%0d] got %h want %h", i,
                     mem_to_rf_bus[31:0], want[i]);
         end
      end
   endtask

   task automatic test_stall_hold();
      stall = GO;
      ex_to_mem_bus = mk('0, 8'h08, 32'h200, 1'b1, 1'b1, 5'd9,
                         32'h2000_0010);
      tick();
      data_sram_rdata = 32'hDEAD_BEEF;
      stall = HOLD;
      ex_to_mem_bus = mk('0, 8'h00, 32'h204, 1'b0, 1'b1, 5'd1, 32'h55);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin
            tick();
            data_sram_rdata = 32'h0;
         end
         @(negedge clk);
         tests++;
         if (mem_to_rf_bus[31:0] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL stall_hold[%0d] got %h want deadbeef", c,
                     mem_to_rf_bus[31:0]);
         end
      end
   endtask

   task automatic test_bubble();
      stall = GO;
      ex_to_mem_bus = mk({2'b11, 64'h1}, 8'h00, 32'h300, 1'b0, 1'b1,
                         5'd7, 32'h77);
      tick();
      stall = BUB;
      tick();
      @(negedge clk);
      tests++;
      if (mem_to_rf_bus[37] !== 1'b0 || mem_hilo_bus[65:64] !== 2'b00
          || mem_to_wb_bus[69:38] !== 32'h0) begin
         fails++;
         $display("FAIL bubble we=%b hilo_we=%b pc=%h want 0 0 0",
                  mem_to_rf_bus[37], mem_hilo_bus[65:64],
                  mem_to_wb_bus[69:38]);
      end
      tests++;
      if (mem_to_wb_bus !== '0) begin
         fails++; $display("FAIL bubble_wb got %h want 0", mem_to_wb_bus);
      end
   endtask

   task automatic test_hilo();
      logic [65:0] h;
      h = {1'b1, 1'b1, 32'h0000_0002, 32'hFFFF_FFFE};
      stall = GO;
      ex_to_mem_bus = mk(h, 8'h00, 32'h400, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      @(negedge clk);
      tests++;
      if (mem_hilo_bus !== h) begin
         fails++; $display("FAIL hilo got %h want %h", mem_hilo_bus, h);
      end
      tests++;
      if (mem_to_wb_bus[135:70] !== h) begin
         fails++;
         $display("FAIL hilo_wb got %h want %h", mem_to_wb_bus[135:70], h);
      end
   endtask

   task automatic test_async_reset();
      stall = GO;
      ex_to_mem_bus = mk({2'b10, 64'h5}, 8'h08, 32'h500, 1'b1, 1'b1,
                         5'd4, 32'h3000_0000);
      tick();
      data_sram_rdata = 32'hCAFE_F00D;
      stall = HOLD;
      tick();
      data_sram_rdata = 32'h1111_1111;
      @(negedge clk);
      tests++;
      if (mem_to_rf_bus[31:0] !== 32'hCAFE_F00D) begin
         fails++;
         $display("FAIL pre_reset_hold got %h want cafef00d",
                  mem_to_rf_bus[31:0]);
      end
      #2 resetn = 1'b0;
      m_instr = '0; m_first = 1'b0; m_held = '0;
      #1;
      tests++;
      if (mem_to_wb_bus !== '0 || mem_to_rf_bus !== '0
          || mem_hilo_bus !== '0) begin
         fails++;
         $display("FAIL async_reset wb=%h rf=%h hilo=%h want 0",
                  mem_to_wb_bus, mem_to_rf_bus, mem_hilo_bus);
      end
      tick();
      @(negedge clk);
      resetn = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         data_sram_rdata = $urandom;
         @(negedge clk);
         tests++;
         if (mem_to_wb_bus !== '0 || mem_to_rf_bus !== '0) begin
            fails++;
            $display("FAIL post_reset[%0d] wb=%h rf=%h want 0", c,
                     mem_to_wb_bus, mem_to_rf_bus);
         end
      end
   endtask

   task automatic test_random();
      int          kind, s;
      logic [7:0]  op;
      logic        sel, we;
      logic [135:0] w;
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 9);
         op = 8'h00; sel = 1'b0; we = 1'b1;
         if (kind <= 4) begin
            op = 8'h80 >> kind; sel = 1'b1;
         end else if (kind <= 7) begin
            op = 8'h04 >> (kind - 5); we = 1'b0;
         end else if (kind == 9) begin
            sel = 1'b1;
         end
         ex_to_mem_bus = mk({$urandom, $urandom, $urandom}, op, $urandom,
                            sel, we, 5'($urandom), $urandom);
         s = $urandom_range(0, 9);
         stall = 6'($urandom) & 6'b100111;
         if (s >= 5) stall[3] = 1'b1;
         if (s >= 7) stall[4] = 1'b1;
         tick();
         data_sram_rdata = $urandom;
         @(negedge clk);
         w = exp_wb();
         tests++;
         if (mem_to_wb_bus !== w) begin
            fails++;
            $display("FAIL rand_wb[%0d] got %h want %h", n,
                     mem_to_wb_bus, w);
         end
         tests++;
         if (mem_to_rf_bus !== w[37:0]) begin
            fails++;
            $display("FAIL rand_rf[%0d] got %h want %h", n,
                     mem_to_rf_bus, w[37:0]);
         end
         tests++;
         if (mem_hilo_bus !== w[135:70]) begin
            fails++;
            $display("FAIL rand_hilo[%0d] got %h want %h", n,
                     mem_hilo_bus, w[135:70]);
         end
      end
   endtask

   initial begin
      m_instr = '0; m_first = 1'b0; m_held = '0;
      resetn = 1'b0;
      stall = GO;
      ex_to_mem_bus = '0;
      data_sram_rdata = '0;
      test_reset();
      test_load_ext();
      test_stall_hold();
      test_bubble();
      test_hilo();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
